mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter N_PORTS, default 3: number of requester ports; port 0 = downloader, 1 = eraser, 2 = CPU.
REQ-002 SHALL have parameter AW, default 25: address width.
REQ-003 SHALL have parameter DW, default 8: data width.
REQ-004 SHALL have parameter MODE, default ARB_FIXED: ARB_FIXED gives lowest index highest priority; ARB_RR is round-robin.
REQ-005 SHALL have ports, in this order:
- clk  in  1  sole clock, system clock domain.
- reset  in  1  asynchronous, active-high.
- slot_ena  in  1  one-cycle strobe marking an SDRAM slot boundary, aligned to clkref.
- port_req  in  N_PORTS  per-port request level.
- port_we  in  N_PORTS  per-port write (1) / read (0).
- port_addr  in  N_PORTS*AW  flattened; port i at [i*AW +: AW].
- port_din  in  N_PORTS*DW  flattened write data.
- port_ack  out  N_PORTS  one-cycle completion pulse.
- port_dout  out  N_PORTS*DW  per-port read data, held until the next read completion on that port.
- mem_addr  out  AW  to sdram addr.
- mem_din  out  DW  to sdram din.
- mem_we  out  1  to sdram we.
- mem_oe  out  1  to sdram oe.
- mem_dout  in  DW  from sdram dout.
- busy  out  1  high while a slot is owned.

Function
REQ-006 SHALL implement two states: IDLE and OWN.
REQ-007 All arbitration and transitions SHALL occur only in cycles where slot_ena=1; other cycles hold state.
REQ-008 IDLE, slot_ena=1, any eligible req: SHALL latch winner index, addr, din and we; drive mem_*; go to OWN.
REQ-009 IDLE, slot_ena=1, no eligible req: SHALL stay in IDLE.
REQ-010 OWN, slot_ena=1 (completion boundary): SHALL capture mem_dout into port_dout[winner] for reads only, then assert port_ack[winner] on the following cycle for exactly one cycle.
REQ-011 At the completion boundary, the arbiter SHALL re-arbitrate in the same cycle (back-to-back slots): if an eligible req exists it stays in OWN with the new winner, otherwise it goes to IDLE.
REQ-012 The port completing at a boundary SHALL be ineligible at that same boundary, since its req is still high until it sees ack.
REQ-013 ARB_FIXED: the winner SHALL be the lowest-index eligible req.
REQ-014 ARB_RR: the search SHALL start at (last_winner+1) mod N_PORTS and wrap; last_winner resets to N_PORTS-1, so port 0 is first.
REQ-015 mem_we SHALL equal the latched we in OWN.
REQ-016 mem_oe SHALL equal ~we in OWN.
REQ-017 In IDLE, mem_we=0, mem_oe=0, and mem_addr/mem_din SHALL hold their last values.
REQ-018 busy SHALL be 1 iff state=OWN.
REQ-019 Inputs of the owning port SHALL NOT be re-sampled during OWN.
REQ-020 A req drop mid-slot SHALL NOT abort the slot; the ack is still issued.
REQ-021 Latency from slot_ena grant to ack SHALL be exactly one slot plus one cycle.
REQ-022 At most one port_ack bit SHALL be high in any cycle.
REQ-023 If N_PORTS=1, the arbiter SHALL degenerate to a slot-aligned register stage with identical timing.

Reset
REQ-024 On reset assertion, asynchronously: state=IDLE, mem_we=0, mem_oe=0, mem_addr=0, mem_din=0, port_ack=0, port_dout=0, busy=0, last_winner=N_PORTS-1.
REQ-025 Reset during OWN SHALL abort the slot with no ack, and the write SHALL NOT be retried.
REQ-026 Operation SHALL resume at the first slot_ena after reset deassertion.

Structure
REQ-027 Package lm80c_mem_pkg SHALL hold the arb_mode_t enum (ARB_FIXED, ARB_RR) and the state enum (IDLE, OWN).
REQ-028 Sub-module rr_picker SHALL contain the combinational rotating-mask priority encoder.
- Inputs: req vector, start index, enable mask.
- Outputs: valid, index.
- Fixed mode uses start=0.

Verification
REQ-029 MODE=ARB_FIXED; ports 0 and 2 req together at a boundary -> port 0 granted; port 2 granted at the next boundary and acked one slot later.
REQ-030 MODE=ARB_RR; all three req continuously -> grant order 0,1,2,0,1,2; each ack exactly once per grant.
REQ-031 Port 2 read at addr 0x00_8241 with mem_dout=0xA5 at completion -> port_dout[2]=0xA5; ack on boundary+1 cycle; mem_oe=1 and mem_we=0 during the slot.
REQ-032 Port 0 write 0x3C at 0x0000 with req held high through ack -> not re-granted at the completion boundary; re-granted at the following boundary.
REQ-033 Reset asserted mid-OWN -> no ack; all outputs zero the same cycle; the first slot_ena after release grants the pending req.
REQ-034 No req for 10 slots -> busy=0, mem_we=0, mem_oe=0 throughout; mem_addr unchanged.

Source files
------------

// File: rtl/lm80c_mem_pkg.sv
// Shared types for the LM80C memory arbiter.
//   arb_mode_t  : arbitration policy selector (fixed priority / round-robin)
//   arb_state_t : arbiter FSM state encoding (IDLE / OWN)
package lm80c_mem_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Rotating-start priority encoder: finds the first request at or after
// i_start (wrapping) that is also enabled by i_mask.
//   i_req     : request vector
//   i_start   : index where the search begins
//   i_mask    : per-port enable (0 removes a port from the search)
//   o_valid_c : any eligible request found
//   o_idx_c   : index of the chosen request
module rr_picker #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  input  logic [N-1:0]  i_mask,
  output logic          o_valid_c,
  output logic [IW-1:0] o_idx_c
);

  logic [N-1:0] w_elig;

  // Search [start, N) first, then wrap to [0, start).
  always_comb begin
    w_elig    = i_req & i_mask;
    o_valid_c = 1'b0;
    o_idx_c   = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!o_valid_c && (j >= 32'(i_start)) && w_elig[j]) begin
        o_valid_c = 1'b1;
        o_idx_c   = IW'(j);
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (!o_valid_c && (j < 32'(i_start)) && w_elig[j]) begin
        o_valid_c = 1'b1;
        o_idx_c   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Slot-aligned SDRAM arbiter for N_PORTS requesters (0 downloader, 1 eraser,
// 2 CPU). A port owns the memory for exactly one slot; the ack pulses the
// cycle after the completing slot boundary.
//   clk, reset           : clock, async active-high reset
//   slot_ena             : slot boundary strobe
//   port_req/we/addr/din : per-port request (addr/din flattened)
//   port_ack, port_dout  : per-port completion pulse and held read data
//   mem_addr/din/we/oe   : to SDRAM controller; mem_dout from it
//   busy                 : a slot is currently owned
module mem_arbiter
  import lm80c_mem_pkg::*;
#(
  parameter int unsigned N_PORTS = 3,
  parameter int unsigned AW      = 25,
  parameter int unsigned DW      = 8,
  parameter arb_mode_t   MODE    = ARB_FIXED
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  slot_ena,
  input  logic [N_PORTS-1:0]    port_req,
  input  logic [N_PORTS-1:0]    port_we,
  input  logic [N_PORTS*AW-1:0] port_addr,
  input  logic [N_PORTS*DW-1:0] port_din,
  output logic [N_PORTS-1:0]    port_ack,
  output logic [N_PORTS*DW-1:0] port_dout,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_din,
  output logic                  mem_we,
  output logic                  mem_oe,
  input  logic [DW-1:0]         mem_dout,
  output logic                  busy
);

  localparam int unsigned IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [IW-1:0]       r_win;
  logic [IW-1:0]       r_last;
  logic                r_we;
  logic [AW-1:0]       r_addr;
  logic [DW-1:0]       r_din;
  logic                r_mem_we;
  logic                r_mem_oe;
  logic [N_PORTS-1:0]  r_ack;
  logic [DW-1:0]       r_dout [N_PORTS];

  logic [AW-1:0]       w_addr_arr [N_PORTS];
  logic [DW-1:0]       w_din_arr  [N_PORTS];
  logic [N_PORTS-1:0]  w_mask;
  logic [IW-1:0]       w_start;
  logic                w_valid;
  logic [IW-1:0]       w_idx;
  logic                w_grant;
  logic                w_complete;

  // Unflatten per-port buses for indexed selection.
  always_comb begin
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      w_addr_arr[i] = port_addr[i*AW +: AW];
      w_din_arr[i]  = port_din[i*DW +: DW];
    end
  end

  // The completing port still holds req until it sees ack; exclude it.
  always_comb begin
    w_mask = '1;
    if (r_state == OWN) begin
      w_mask[r_win] = 1'b0;
    end
  end

  // Round-robin starts one past the last winner; fixed always starts at 0.
  always_comb begin
    w_start = '0;
    if (MODE == ARB_RR) begin
      w_start = (r_last == IW'(N_PORTS - 1)) ? '0 : r_last + IW'(1);
    end
  end

  rr_picker #(
    .N  (N_PORTS),
    .IW (IW)
  ) u_picker (
    .i_req     (port_req),
    .i_start   (w_start),
    .i_mask    (w_mask),
    .o_valid_c (w_valid),
    .o_idx_c   (w_idx)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: only slot boundaries move the FSM; OWN re-arbitrates directly.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (slot_ena && w_valid) w_state_nxt = OWN;
      OWN:  if (slot_ena)            w_state_nxt = w_valid ? OWN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM-derived control strobes.
  always_comb begin
    w_grant    = slot_ena && w_valid;
    w_complete = slot_ena && (r_state == OWN);
  end

  // Slot datapath: latch the winner's request, return completion data/ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win    <= '0;
      r_last   <= IW'(N_PORTS - 1);
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_din    <= '0;
      r_mem_we <= 1'b0;
      r_mem_oe <= 1'b0;
      r_ack    <= '0;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        r_dout[i] <= '0;
      end
    end else begin
      r_ack <= '0;
      if (w_complete) begin
        r_ack[r_win] <= 1'b1;
        if (!r_we) begin
          r_dout[r_win] <= mem_dout;
        end
      end
      if (w_grant) begin
        r_win    <= w_idx;
        r_last   <= w_idx;
        r_we     <= port_we[w_idx];
        r_addr   <= w_addr_arr[w_idx];
        r_din    <= w_din_arr[w_idx];
        r_mem_we <= port_we[w_idx];
        r_mem_oe <= ~port_we[w_idx];
      end else if (slot_ena) begin
        // Falling back to IDLE: strobes drop, address/data hold.
        r_mem_we <= 1'b0;
        r_mem_oe <= 1'b0;
      end
    end
  end

  always_comb begin
    port_dout = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      port_dout[i*DW +: DW] = r_dout[i];
    end
  end

  assign port_ack = r_ack;
  assign mem_addr = r_addr;
  assign mem_din  = r_din;
  assign mem_we   = r_mem_we;
  assign mem_oe   = r_mem_oe;
  assign busy     = (r_state == OWN);

endmodule
